// File: rtl/axi4_fifo_adapter_pkg.sv
// ---------------------------------------------------------------------------
// axi4_fifo_adapter_pkg
//
// Shared definitions for the AXI4-to-FIFO bridge and the adapter block:
//   - FSM state encodings (plain 3-bit constants for legacy tools)
//   - FIFO command type codes (CMD_WT / CMD_RD)
//   - AXI response codes (RESP_OKAY / RESP_SLVERR)
//   - ADDR_STEP: the word-address increment between consecutive beats
//   - word_addr(): converts AXI byte address bits [27:4] into the
//     27-bit FIFO word address
// ---------------------------------------------------------------------------
package axi4_fifo_adapter_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_DATA    = 3'd1;
  localparam logic [2:0] ST_WR_RESP    = 3'd2;
  localparam logic [2:0] ST_RD_CMD     = 3'd3;
  localparam logic [2:0] ST_RD_DATA    = 3'd4;
  localparam logic [2:0] ST_ERR_WDRAIN = 3'd5;
  localparam logic [2:0] ST_ERR_RESP   = 3'd6;

  localparam logic CMD_WT = 1'b0;
  localparam logic CMD_RD = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [26:0] ADDR_STEP = 27'd8;

  // One 128-bit AXI beat covers 16 bytes; the FIFO side counts in
  // 8-unit steps per beat, hence the 3-bit left shift of addr[27:4].
  function automatic logic [26:0] word_addr(input logic [23:0] addr_hi);
    return {addr_hi, 3'b000};
  endfunction

endpackage

// File: rtl/axi4_fifo_adapter.sv
// ---------------------------------------------------------------------------
// axi4_fifo_adapter
//
// Bridges an AXI4 slave port (128-bit data, one transaction outstanding)
// onto a FIFO command/response pair.
//
// Ports:
//   clk, rstn          single clock, asynchronous active-low reset
//   aw*/w*/b*          AXI write address, data and response channels
//   ar*/r*             AXI read address and data channels
//   io_fifo_cmd_*      command master: type (0 write / 1 read), word
//                      address, burst count, write data and byte mask
//   io_fifo_rsp_*      response slave carrying read data
//
// Writes emit one single-beat command per W beat. Reads emit one burst
// command, then R beats are passed straight through from the response
// FIFO. Bursts longer than MAX_LEN are answered with SLVERR and never
// reach the FIFO.
// ---------------------------------------------------------------------------
module axi4_fifo_adapter
  import axi4_fifo_adapter_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int MAX_LEN = 31
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic            wvalid,
  output logic            wready,
  input  logic [127:0]    wdata,
  input  logic [15:0]     wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  input  logic            arvalid,
  output logic            arready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  output logic            rvalid,
  input  logic            rready,
  output logic [ID_W-1:0] rid,
  output logic [127:0]    rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            io_fifo_cmd_valid,
  input  logic            io_fifo_cmd_ready,
  output logic            io_fifo_cmd_type,
  output logic [26:0]     io_fifo_cmd_addr,
  output logic [5:0]      io_fifo_cmd_burst_cnt,
  output logic [127:0]    io_fifo_cmd_wt_data,
  output logic [15:0]     io_fifo_cmd_wt_mask,
  input  logic            io_fifo_rsp_valid,
  output logic            io_fifo_rsp_ready,
  input  logic [127:0]    io_fifo_rsp_data
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]      state;
  logic            rst_done;
  logic            prio_rd;
  logic            resp_err;
  logic            wr_done;
  logic [ID_W-1:0] id_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_cnt;
  logic [26:0]     waddr;

  logic            grant_wr;
  logic            grant_rd;
  logic            cmd_fire;
  logic            w_fire;
  logic            w_final;
  logic            r_fire;
  logic            rd_beats;
  logic [26:0]     load_addr;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[31:28], awaddr[3:0], araddr[31:28], araddr[3:0]};

  // Address grant. rst_done keeps both readies low while reset is held
  // and for the first edge after release. prio_rd=1 means read wins a
  // tie, and it flips to the opposite of whichever side was granted.
  assign grant_wr = rst_done && (state == ST_IDLE) && awvalid && (!arvalid || !prio_rd);
  assign grant_rd = rst_done && (state == ST_IDLE) && arvalid && (!awvalid || prio_rd);
  assign awready  = grant_wr;
  assign arready  = grant_rd;

  // A new W beat can only be taken when the command register is free or
  // is emptying this cycle, so a stalled command is never overwritten.
  assign cmd_fire = io_fifo_cmd_valid && io_fifo_cmd_ready;
  assign wready   = ((state == ST_WR_DATA) && !wr_done && (!io_fifo_cmd_valid || io_fifo_cmd_ready))
                 || (state == ST_ERR_WDRAIN);
  assign w_fire   = wvalid && wready;
  assign w_final  = wlast || (beat_cnt == len_q);

  // The address register advances on each command handshake; a beat
  // loaded in the same cycle as a handshake must use the advanced value.
  assign load_addr = cmd_fire ? (waddr + ADDR_STEP) : waddr;

  assign bvalid = (state == ST_WR_RESP);
  assign bresp  = (bvalid && resp_err) ? RESP_SLVERR : RESP_OKAY;
  assign bid    = bvalid ? id_q : '0;

  // R channel is a pass-through of the response FIFO in RD_DATA and a
  // locally generated zero/SLVERR stream in ERR_RESP.
  assign rd_beats          = (state == ST_RD_DATA) || (state == ST_ERR_RESP);
  assign rvalid            = ((state == ST_RD_DATA) && io_fifo_rsp_valid) || (state == ST_ERR_RESP);
  assign io_fifo_rsp_ready = (state == ST_RD_DATA) && rready;
  assign rdata             = (state == ST_RD_DATA) ? io_fifo_rsp_data : '0;
  assign rresp             = (state == ST_ERR_RESP) ? RESP_SLVERR : RESP_OKAY;
  assign rlast             = rd_beats && (beat_cnt == len_q);
  assign rid               = rd_beats ? id_q : '0;
  assign r_fire            = rvalid && rready;

  // Main FSM plus command register. The command register clears on its
  // handshake unless a new command is loaded in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                 <= ST_IDLE;
      rst_done              <= 1'b0;
      prio_rd               <= 1'b0;
      resp_err              <= 1'b0;
      wr_done               <= 1'b0;
      id_q                  <= '0;
      len_q                 <= '0;
      beat_cnt              <= '0;
      waddr                 <= '0;
      io_fifo_cmd_valid     <= 1'b0;
      io_fifo_cmd_type      <= CMD_WT;
      io_fifo_cmd_addr      <= '0;
      io_fifo_cmd_burst_cnt <= '0;
      io_fifo_cmd_wt_data   <= '0;
      io_fifo_cmd_wt_mask   <= '0;
    end else begin
      rst_done <= 1'b1;
      if (cmd_fire) begin
        io_fifo_cmd_valid <= 1'b0;
        waddr             <= waddr + ADDR_STEP;
      end
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            id_q     <= awid;
            len_q    <= awlen;
            waddr    <= word_addr(awaddr[27:4]);
            beat_cnt <= '0;
            wr_done  <= 1'b0;
            resp_err <= 1'b0;
            prio_rd  <= 1'b1;
            state    <= (awlen > MAX_LEN_B) ? ST_ERR_WDRAIN : ST_WR_DATA;
          end else if (grant_rd) begin
            id_q     <= arid;
            len_q    <= arlen;
            beat_cnt <= '0;
            prio_rd  <= 1'b0;
            if (arlen > MAX_LEN_B) begin
              state <= ST_ERR_RESP;
            end else begin
              io_fifo_cmd_valid     <= 1'b1;
              io_fifo_cmd_type      <= CMD_RD;
              io_fifo_cmd_addr      <= word_addr(araddr[27:4]);
              io_fifo_cmd_burst_cnt <= arlen[5:0] + 6'd1;
              io_fifo_cmd_wt_data   <= '0;
              io_fifo_cmd_wt_mask   <= '0;
              state                 <= ST_RD_CMD;
            end
          end
        end
        ST_WR_DATA: begin
          if (w_fire) begin
            io_fifo_cmd_valid     <= 1'b1;
            io_fifo_cmd_type      <= CMD_WT;
            io_fifo_cmd_addr      <= load_addr;
            io_fifo_cmd_burst_cnt <= 6'd1;
            io_fifo_cmd_wt_data   <= wdata;
            io_fifo_cmd_wt_mask   <= ~wstrb;
            beat_cnt              <= beat_cnt + 8'd1;
            if (w_final) wr_done <= 1'b1;
          end else if (wr_done && cmd_fire) begin
            state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bready) state <= ST_IDLE;
        end
        ST_RD_CMD: begin
          if (cmd_fire) state <= ST_RD_DATA;
        end
        ST_RD_DATA, ST_ERR_RESP: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (rlast) state <= ST_IDLE;
          end
        end
        ST_ERR_WDRAIN: begin
          if (w_fire && wlast) begin
            resp_err <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_fifo_adapter.sv
// ---------------------------------------------------------------------------
// tb_axi4_fifo_adapter
//
// Directed bench for axi4_fifo_adapter. Inputs change 1 time unit after
// a rising edge; outputs are checked on the falling edge. A monitor logs
// every command handshake so beat loss/duplication can be detected.
// ---------------------------------------------------------------------------
module tb_axi4_fifo_adapter;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            awvalid, awready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic            wvalid, wready;
  logic [127:0]    wdata;
  logic [15:0]     wstrb;
  logic            wlast;
  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            arvalid, arready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic            rvalid, rready;
  logic [ID_W-1:0] rid;
  logic [127:0]    rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            cmd_valid, cmd_ready, cmd_type;
  logic [26:0]     cmd_addr;
  logic [5:0]      cmd_burst;
  logic [127:0]    cmd_data;
  logic [15:0]     cmd_mask;
  logic            rsp_valid, rsp_ready;
  logic [127:0]    rsp_data;

  int n_asserts = 0;
  int n_fails   = 0;
  int cmd_count = 0;
  int base;
  int cnt_ok;
  logic [26:0]  log_addr [64];
  logic [127:0] log_data [64];

  axi4_fifo_adapter #(.ID_W(ID_W), .MAX_LEN(31)) dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .io_fifo_cmd_valid(cmd_valid), .io_fifo_cmd_ready(cmd_ready), .io_fifo_cmd_type(cmd_type),
    .io_fifo_cmd_addr(cmd_addr), .io_fifo_cmd_burst_cnt(cmd_burst),
    .io_fifo_cmd_wt_data(cmd_data), .io_fifo_cmd_wt_mask(cmd_mask),
    .io_fifo_rsp_valid(rsp_valid), .io_fifo_rsp_ready(rsp_ready), .io_fifo_rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Command monitor: records each accepted command in order
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (cmd_count < 64) begin
        log_addr[cmd_count] = cmd_addr;
        log_data[cmd_count] = cmd_data;
      end
      cmd_count++;
    end
  end

  // Commits the currently driven inputs across one rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] beatData(input int j);
    return {4{32'hA5A5_0000 | 32'(j)}};
  endfunction

  task automatic idleInputs();
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0;
    bready = 1; rready = 1; cmd_ready = 1;
    rsp_valid = 0; rsp_data = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    idleInputs();
    rstn = 1;
    #2 rstn = 0;
    awvalid = 1; arvalid = 1; wvalid = 1; rsp_valid = 1;
    #1;
    checkOutput("reset_awready",   128'(awready),   128'(0));
    checkOutput("reset_arready",   128'(arready),   128'(0));
    checkOutput("reset_wready",    128'(wready),    128'(0));
    checkOutput("reset_bvalid",    128'(bvalid),    128'(0));
    checkOutput("reset_rvalid",    128'(rvalid),    128'(0));
    checkOutput("reset_cmd_valid", 128'(cmd_valid), 128'(0));
    checkOutput("reset_rsp_ready", 128'(rsp_ready), 128'(0));
    checkOutput("reset_cmd_addr",  128'(cmd_addr),  128'(0));
    idleInputs();
    applyStimulus();
    applyStimulus();
    rstn = 1;
    applyStimulus();

    // ---------------- write burst, len 3 ----------------
    base = cmd_count;
    awvalid = 1; awaddr = 32'h100; awlen = 8'd3; awid = 4'h5;
    @(negedge clk);
    checkOutput("wr_awready", 128'(awready), 128'(1));
    checkOutput("wr_arready", 128'(arready), 128'(0));
    applyStimulus();
    awvalid = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        wvalid = 1; wdata = beatData(k); wstrb = 16'hFFFF; wlast = (k == 3);
      end else begin
        wvalid = 0; wlast = 0;
      end
      @(negedge clk);
      checkOutput("wr_wready", 128'(wready), 128'(k < 4));
      if (k > 0) begin
        checkOutput("wr_cmd_valid", 128'(cmd_valid), 128'(1));
        checkOutput("wr_cmd_type",  128'(cmd_type),  128'(0));
        checkOutput("wr_cmd_addr",  128'(cmd_addr),  128'(27'h80 + 27'(8 * (k - 1))));
        checkOutput("wr_cmd_burst", 128'(cmd_burst), 128'(1));
        checkOutput("wr_cmd_mask",  128'(cmd_mask),  128'(0));
        checkOutput("wr_cmd_data",  cmd_data,        beatData(k - 1));
      end
      applyStimulus();
    end
    @(negedge clk);
    checkOutput("wr_bvalid",    128'(bvalid),    128'(1));
    checkOutput("wr_bresp",     128'(bresp),     128'(2'b00));
    checkOutput("wr_bid",       128'(bid),       128'(5));
    checkOutput("wr_cmd_idle",  128'(cmd_valid), 128'(0));
    applyStimulus();
    @(negedge clk);
    checkOutput("wr_bvalid_drop", 128'(bvalid), 128'(0));
    checkOutput("wr_cmd_count",   128'(cmd_count - base), 128'(4));

    // ---------------- read burst, len 7 ----------------
    applyStimulus();
    base = cmd_count;
    arvalid = 1; araddr = 32'h200; arlen = 8'd7; arid = 4'h3;
    @(negedge clk);
    checkOutput("rd_arready", 128'(arready), 128'(1));
    checkOutput("rd_awready", 128'(awready), 128'(0));
    applyStimulus();
    arvalid = 0;
    @(negedge clk);
    checkOutput("rd_cmd_valid", 128'(cmd_valid), 128'(1));
    checkOutput("rd_cmd_type",  128'(cmd_type),  128'(1));
    checkOutput("rd_cmd_addr",  128'(cmd_addr),  128'(27'h100));
    checkOutput("rd_cmd_burst", 128'(cmd_burst), 128'(8));
    checkOutput("rd_rvalid_early", 128'(rvalid), 128'(0));
    applyStimulus();
    for (int i = 0; i < 8; i++) begin
      rsp_valid = 1; rsp_data = beatData(16 + i);
      @(negedge clk);
      checkOutput("rd_rvalid",    128'(rvalid),    128'(1));
      checkOutput("rd_rdata",     rdata,           beatData(16 + i));
      checkOutput("rd_rlast",     128'(rlast),     128'(i == 7));
      checkOutput("rd_rid",       128'(rid),       128'(3));
      checkOutput("rd_rresp",     128'(rresp),     128'(2'b00));
      checkOutput("rd_rsp_ready", 128'(rsp_ready), 128'(1));
      applyStimulus();
    end
    @(negedge clk);
    checkOutput("rd_stray_rvalid",    128'(rvalid),    128'(0));
    checkOutput("rd_stray_rsp_ready", 128'(rsp_ready), 128'(0));
    checkOutput("rd_cmd_count", 128'(cmd_count - base), 128'(1));
    rsp_valid = 0;
    applyStimulus();

    // ---------------- round-robin ties: W, R, W, R ----------------
    awvalid = 1; awaddr = 32'h40; awlen = 0; awid = 4'h1;
    arvalid = 1; araddr = 32'h80; arlen = 0; arid = 4'h2;
    rsp_valid = 1; rsp_data = beatData(99);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      checkOutput("tie_awready", 128'(awready), 128'(g % 2 == 0));
      checkOutput("tie_arready", 128'(arready), 128'(g % 2 == 1));
      applyStimulus();
      if (g % 2 == 0) begin
        wvalid = 1; wlast = 1; wdata = beatData(50 + g); wstrb = 16'h00FF;
        applyStimulus();
        wvalid = 0; wlast = 0;
        @(negedge clk);
        checkOutput("tie_wr_mask", 128'(cmd_mask), 128'(16'hFF00));
        checkOutput("tie_wr_addr", 128'(cmd_addr), 128'(27'h20));
        applyStimulus();
        @(negedge clk);
        checkOutput("tie_bvalid", 128'(bvalid), 128'(1));
        applyStimulus();
      end else begin
        applyStimulus();
        @(negedge clk);
        checkOutput("tie_rvalid", 128'(rvalid), 128'(1));
        checkOutput("tie_rlast",  128'(rlast),  128'(1));
        checkOutput("tie_rid",    128'(rid),    128'(2));
        applyStimulus();
      end
    end
    awvalid = 0; arvalid = 0; rsp_valid = 0;
    applyStimulus();

    // ---------------- command back-pressure during write ----------------
    base = cmd_count;
    awvalid = 1; awaddr = 32'h1000; awlen = 8'd2; awid = 4'h7;
    @(negedge clk);
    checkOutput("stall_awready", 128'(awready), 128'(1));
    applyStimulus();
    awvalid = 0;
    cmd_ready = 0;
    wvalid = 1; wdata = beatData(60); wstrb = 16'hFFFF; wlast = 0;
    @(negedge clk);
    checkOutput("stall_wready_first", 128'(wready), 128'(1));
    applyStimulus();
    wdata = beatData(61);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("stall_cmd_valid", 128'(cmd_valid), 128'(1));
      checkOutput("stall_cmd_data",  cmd_data,        beatData(60));
      checkOutput("stall_cmd_addr",  128'(cmd_addr),  128'(27'h800));
      checkOutput("stall_wready",    128'(wready),    128'(0));
      applyStimulus();
    end
    cmd_ready = 1;
    @(negedge clk);
    checkOutput("stall_wready_drain", 128'(wready), 128'(1));
    applyStimulus();
    wdata = beatData(62); wlast = 1;
    @(negedge clk);
    checkOutput("stall_cmd1_data", cmd_data,       beatData(61));
    checkOutput("stall_cmd1_addr", 128'(cmd_addr), 128'(27'h808));
    applyStimulus();
    wvalid = 0; wlast = 0;
    @(negedge clk);
    checkOutput("stall_cmd2_data", cmd_data,       beatData(62));
    checkOutput("stall_cmd2_addr", 128'(cmd_addr), 128'(27'h810));
    applyStimulus();
    @(negedge clk);
    checkOutput("stall_bvalid", 128'(bvalid), 128'(1));
    checkOutput("stall_bresp",  128'(bresp),  128'(2'b00));
    checkOutput("stall_bid",    128'(bid),    128'(7));
    applyStimulus();
    checkOutput("stall_cmd_count", 128'(cmd_count - base), 128'(3));
    checkOutput("stall_log0_data", log_data[base],     beatData(60));
    checkOutput("stall_log1_data", log_data[base + 1], beatData(61));
    checkOutput("stall_log2_data", log_data[base + 2], beatData(62));
    checkOutput("stall_log2_addr", 128'(log_addr[base + 2]), 128'(27'h810));

    // ---------------- oversized write, awlen 40 ----------------
    base = cmd_count;
    awvalid = 1; awaddr = 32'h300; awlen = 8'd40; awid = 4'h9;
    @(negedge clk);
    checkOutput("errw_awready", 128'(awready), 128'(1));
    applyStimulus();
    awvalid = 0;
    cnt_ok = 0;
    for (int i = 0; i < 41; i++) begin
      wvalid = 1; wlast = (i == 40); wdata = beatData(i); wstrb = 16'hFFFF;
      @(negedge clk);
      if (wready === 1'b1 && cmd_valid === 1'b0) cnt_ok++;
      applyStimulus();
    end
    wvalid = 0; wlast = 0;
    checkOutput("errw_beats_accepted", 128'(cnt_ok), 128'(41));
    @(negedge clk);
    checkOutput("errw_bvalid", 128'(bvalid), 128'(1));
    checkOutput("errw_bresp",  128'(bresp),  128'(2'b10));
    checkOutput("errw_bid",    128'(bid),    128'(9));
    applyStimulus();
    checkOutput("errw_cmd_count", 128'(cmd_count - base), 128'(0));

    // ---------------- oversized read, arlen 40 ----------------
    base = cmd_count;
    arvalid = 1; araddr = 32'h400; arlen = 8'd40; arid = 4'h4;
    @(negedge clk);
    checkOutput("errr_arready", 128'(arready), 128'(1));
    applyStimulus();
    arvalid = 0;
    cnt_ok = 0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1 && rdata === 128'd0 && rresp === 2'b10 &&
          rlast === (i == 40) && rid === 4'h4) cnt_ok++;
      applyStimulus();
    end
    checkOutput("errr_beats", 128'(cnt_ok), 128'(41));
    @(negedge clk);
    checkOutput("errr_rvalid_end", 128'(rvalid), 128'(0));
    checkOutput("errr_cmd_count", 128'(cmd_count - base), 128'(0));
    applyStimulus();

    // ---------------- reset pulse in the middle of RD_DATA ----------------
    arvalid = 1; araddr = 32'h40; arlen = 8'd7; arid = 4'h6;
    @(negedge clk);
    checkOutput("rst_arready", 128'(arready), 128'(1));
    applyStimulus();
    arvalid = 0;
    applyStimulus();
    rsp_valid = 1; rsp_data = beatData(200);
    applyStimulus();
    applyStimulus();
    checkOutput("rst_pre_rvalid", 128'(rvalid), 128'(1));
    rstn = 0;
    #1;
    checkOutput("rst_rvalid",    128'(rvalid),    128'(0));
    checkOutput("rst_rsp_ready", 128'(rsp_ready), 128'(0));
    checkOutput("rst_rlast",     128'(rlast),     128'(0));
    checkOutput("rst_rdata",     rdata,           128'(0));
    checkOutput("rst_rid",       128'(rid),       128'(0));
    checkOutput("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    checkOutput("rst_awready",   128'(awready),   128'(0));
    checkOutput("rst_arready",   128'(arready),   128'(0));
    rsp_valid = 0;
    applyStimulus();
    rstn = 1;
    applyStimulus();
    awvalid = 1; awaddr = 32'h100; awlen = 0; awid = 4'h2;
    @(negedge clk);
    checkOutput("post_rst_awready", 128'(awready), 128'(1));
    applyStimulus();
    awvalid = 0;
    wvalid = 1; wlast = 1; wdata = beatData(77); wstrb = 16'hFFFF;
    applyStimulus();
    wvalid = 0; wlast = 0;
    @(negedge clk);
    checkOutput("post_rst_cmd_valid", 128'(cmd_valid), 128'(1));
    checkOutput("post_rst_cmd_addr",  128'(cmd_addr),  128'(27'h80));
    checkOutput("post_rst_cmd_data",  cmd_data,        beatData(77));
    applyStimulus();
    @(negedge clk);
    checkOutput("post_rst_bvalid", 128'(bvalid), 128'(1));
    checkOutput("post_rst_bresp",  128'(bresp),  128'(2'b00));
    checkOutput("post_rst_bid",    128'(bid),    128'(2));
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
